router_egress_queue: RTL
========================

# router_egress_queue

Per-output-port egress buffering stage placed directly downstream of the 4-port router. It captures each cycle's `data_out`/`valid` beats from the router into one FIFO per output port. It releases them to the downstream sinks over a valid/ready handshake, absorbing sink back-pressure that the router itself cannot handle. Beats that arrive when a queue has no room are dropped and, optionally, counted.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one data beat; matches the router's `DATA_WIDTH`.
- `DEPTH`, default 4: entries per port FIFO; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `rst`, input, 1: **synchronous, active-high** reset.
- `in_data[3:0]`, input, `DATA_WIDTH` each: router output beats, one per port.
- `in_valid[3:0]`, input, 1 each: beat present on the matching `in_data` this cycle.
- `out_data[3:0]`, output, `DATA_WIDTH` each: head entry of each port FIFO.
- `out_valid[3:0]`, output, 1 each: head entry is valid (FIFO not empty).
- `out_ready[3:0]`, input, 1 each: sink accepts the head entry this cycle.
- `full[3:0]`, output, 1 each: FIFO holds `DEPTH` entries.
- `drop_count[3:0]`, output, 16 each: dropped-beat counters (see Configuration).

## Operation
- The four ports are fully independent, with no cross-port arbitration.
- Each FIFO is show-ahead: `out_data[i]` always reflects the head entry. When `out_valid[i]`=0, `out_data[i]` shows whatever the entry at the read pointer holds and is don't-care.
- Pop: occurs when `out_valid[i] && out_ready[i]` at a rising edge; the read pointer advances.
- Push: occurs when `in_valid[i]` is high and either occupancy < `DEPTH` or a pop happens in the same cycle. The beat is written at the write pointer.
- Drop: when `in_valid[i]` is high, the FIFO is full and there is no same-cycle pop, the beat is discarded. FIFO contents are unchanged.
- Simultaneous push and pop:
  - On a full FIFO, occupancy stays at `DEPTH`, the head advances and the new beat enters at the tail.
  - On an empty FIFO, a pop cannot occur (`out_valid`=0), so only the push takes effect.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is `$clog2(DEPTH)+1` bits, range 0..`DEPTH`.
- `out_ready` while `out_valid`=0 is ignored.
- `in_valid` high with `in_data` unknown is legal when dropped.
- Order is preserved per port: first in, first out.

## Timing
- Reset values, while `rst` is high at an edge:
  - Pointers and occupancy are 0.
  - `out_valid` = 4'b0000 and `full` = 4'b0000.
  - `out_data` = 0 (storage cleared).
  - `drop_count` = 0.
- Reset mid-operation discards all queued beats. Inputs are ignored during any cycle in which `rst` is high.
- Latency: a beat pushed at edge N is visible on `out_data`/`out_valid` after edge N and can pop at edge N+1. Minimum residency is one cycle.
- Throughput is one beat per port per cycle in steady state, including when the FIFO is full, provided `out_ready`=1.
- `full` and `out_valid` are derived from registered occupancy. No combinational path exists from `in_valid` or `in_data` to any output.
- `out_ready` combinationally affects push acceptance only. It does not reach any output.

## Configuration
Controlled by the macro `ROUTER_EGRESS_STATS_EN`.
- Defined:
  - `drop_count[i]` increments by 1 on every dropped beat at port i.
  - It saturates at 16'hFFFF and holds there.
  - It clears only on `rst`.
- Undefined:
  - No counter logic is synthesized.
  - `drop_count[i]` is tied to 0.
  - Drop behaviour itself is unchanged.

## Structure
- Shared package `router_pkg` holds:
  - `NUM_PORTS` = 4.
  - `DROP_CNT_W` = 16.
  - The `DATA_WIDTH` default constant, so the router and this block agree.
- Sub-module `egress_fifo` is a single-port show-ahead FIFO. It holds storage, pointers, occupancy, the push/pop/drop decision, and an optional drop counter.
- The top level instantiates `egress_fifo` `NUM_PORTS` times in a generate loop.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid`=4'hF. Required: `out_valid`=0, `full`=0 and `drop_count`=0 on all ports afterward.
- **Single beat:** push 8'hA5 on port 2 with `out_ready`=1. Required: `out_valid[2]`=1 with `out_data[2]`=8'hA5 one edge later, and the beat pops at the next edge. Other ports stay idle.
- **Fill and drop:** with `DEPTH`=4 and `out_ready[0]`=0, push 8'h01..8'h06 on consecutive cycles. Required:
  - `full[0]`=1 after the 4th beat.
  - Beats 8'h05 and 8'h06 are dropped, and `drop_count[0]`=2 when the macro is defined.
  - Releasing ready drains 01, 02, 03, 04 in order.
- **Full with simultaneous push and pop:** with the FIFO full of 10..13, push 8'h14 while `out_ready`=1. Required: 10 pops, 14 is accepted, occupancy stays 4, and no drop is counted.
- **Wrap-around:** stream 20 beats with random `out_ready` at 50%. Required: the output sequence equals the accepted-input sequence, and pointers wrap with no loss.
- **Reset mid-stream:** with 3 entries queued, pulse `rst` for 1 cycle. Required: `out_valid`=0 on the next cycle and the old entries never reappear.

Source files
------------

// File: rtl/router_egress_queue_pkg.sv
// Shared router constants: port count, drop counter width and the default
// beat width, so the router and its egress queue agree on sizes.
package router_pkg;

  localparam int NUM_PORTS      = 4;
  localparam int DROP_CNT_W     = 16;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

endpackage

// File: rtl/router_egress_queue_if.sv
// Egress queue bus: router-side beats in, sink-side valid/ready out, plus
// per-port full flags and drop counters.
// master: the router/sink side driving beats and ready.
// slave:  the egress queue itself.
interface router_egress_queue_if #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH_DEF
);
  import router_pkg::*;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]                 in_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]                 out_valid;
  logic [NUM_PORTS-1:0]                 out_ready;
  logic [NUM_PORTS-1:0]                 full;
  logic [NUM_PORTS-1:0][DROP_CNT_W-1:0] drop_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, full, drop_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, full, drop_count
  );

endinterface

// File: rtl/router_egress_queue_fifo.sv
// egress_fifo: single-port show-ahead FIFO with push/pop/drop decision.
// Optional drop counter enabled by the ROUTER_EGRESS_STATS_EN macro; when the
// macro is undefined the counter output is tied to zero.
module egress_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
  output drop_cnt_t             drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  pop;
  logic                  push;

  // Status comes only from registered occupancy; the head entry is shown ahead.
  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign out_data  = mem[rd_ptr];

  // A same-cycle pop frees a slot, so a full FIFO can still accept a beat.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);

  // Storage, pointers and occupancy; reset clears storage so out_data reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTER_EGRESS_STATS_EN
  logic      drop;
  drop_cnt_t drop_cnt_q;

  assign drop = in_valid & full & ~pop;

  // Saturating count of discarded beats, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                            drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: rtl/router_egress_queue.sv
// router_egress_queue: one independent egress_fifo per router output port.
// Optional drop statistics controlled by the ROUTER_EGRESS_STATS_EN macro.
module router_egress_queue
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  router_egress_queue_if.slave bus
);

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data_w;
  logic [NUM_PORTS-1:0]                 out_valid_w;
  logic [NUM_PORTS-1:0]                 full_w;
  logic [NUM_PORTS-1:0][DROP_CNT_W-1:0] drop_count_w;

  // Ports never interact, so each gets its own queue.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    egress_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .in_data    (bus.in_data[g]),
      .in_valid   (bus.in_valid[g]),
      .out_data   (out_data_w[g]),
      .out_valid  (out_valid_w[g]),
      .out_ready  (bus.out_ready[g]),
      .full       (full_w[g]),
      .drop_count (drop_count_w[g])
    );
  end

  assign bus.out_data   = out_data_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.full       = full_w;
  assign bus.drop_count = drop_count_w;

endmodule
